// File: rtl/param_cam.sv
// Masked-compare content-addressable memory with a parameterised number of
// compare lanes; a search sweeps the array in ascending chunks of LANES entries.
//
// state  | meaning
// IDLE   | waiting for a search; writes/deletes allowed
// SEARCH | comparing one chunk per cycle; Busy=1, memory frozen
// DONE   | one-cycle Done pulse; results final, new search may start
module param_cam #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int LANES      = 1
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  Writ_Enable,
  input  logic                  Del_Enable,
  input  logic [ADDR_WIDTH-1:0] WR_Addr,
  input  logic [DATA_WIDTH-1:0] Data_IN,
  input  logic                  Search_Start,
  input  logic [DATA_WIDTH-1:0] CMP_Din,
  input  logic [DATA_WIDTH-1:0] CMP_Mask,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Match,
  output logic                  Multi_Match,
  output logic [ADDR_WIDTH-1:0] Match_Addr,
  output logic [ADDR_WIDTH:0]   Match_Count
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int N_CHUNKS  = DEPTH / LANES;
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam logic [ADDR_WIDTH-1:0] LAST_CHUNK = ADDR_WIDTH'(N_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [ADDR_WIDTH-1:0] chunk_left;

  logic [ADDR_WIDTH-1:0] chunk_base;
  logic [LANES-1:0]      lane_hit;
  logic [ADDR_WIDTH:0]   chunk_hits;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic                  chunk_any;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  mem_open;

  // chunk_left counts down, so the chunk being compared is LAST_CHUNK - chunk_left
  always_comb begin
    chunk_base = (LAST_CHUNK - chunk_left) << LANE_BITS;
    lane_hit   = '0;
    chunk_hits = '0;
    first_addr = '0;
    chunk_any  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_hit[l] = valid[chunk_base + ADDR_WIDTH'(l)] &&
                    (((mem[chunk_base + ADDR_WIDTH'(l)] ^ key_q) & mask_q) == '0);
      if (lane_hit[l]) begin
        chunk_hits = chunk_hits + (ADDR_WIDTH+1)'(1);
        if (!chunk_any) first_addr = chunk_base + ADDR_WIDTH'(l);
        chunk_any = 1'b1;
      end
    end
    count_nxt = Match_Count + chunk_hits;
  end

  assign mem_open = (state != SEARCH);

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state       <= IDLE;
      valid       <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      key_q       <= '0;
      mask_q      <= '0;
      chunk_left  <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Match       <= 1'b0;
      Multi_Match <= 1'b0;
      Match_Addr  <= '0;
      Match_Count <= '0;
    end else begin
      // write wins over delete; the search started this edge sees the update
      if (mem_open) begin
        if (Writ_Enable) begin
          mem[WR_Addr]   <= Data_IN;
          valid[WR_Addr] <= 1'b1;
        end else if (Del_Enable) begin
          valid[WR_Addr] <= 1'b0;
        end
      end

      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Search_Start) begin
            state       <= SEARCH;
            Busy        <= 1'b1;
            key_q       <= CMP_Din;
            mask_q      <= CMP_Mask;
            chunk_left  <= LAST_CHUNK;
            Match       <= 1'b0;
            Multi_Match <= 1'b0;
            Match_Addr  <= '0;
            Match_Count <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SEARCH: begin
          Match_Count <= count_nxt;
          Match       <= (count_nxt != '0);
          Multi_Match <= (count_nxt > (ADDR_WIDTH+1)'(1));
          // Match still low means no earlier chunk hit, so this is the lowest
          if (!Match && chunk_any) Match_Addr <= first_addr;
          if (chunk_left == '0) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            chunk_left <= chunk_left - ADDR_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cam.sv
// Directed bench for param_cam: a 1-lane instance and a 2-lane instance share
// the same stimulus; each scenario observes the instance it targets.
module tb_param_cam;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, de = 1'b0, start = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] din = '0, key = '0, mask = '0;

  logic       busy0, done0, match0, multi0;
  logic [1:0] addr0;
  logic [2:0] cnt0;
  logic       busy1, done1, match1, multi1;
  logic [1:0] addr1;
  logic [2:0] cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  param_cam u_dut1 (
    .Clk(clk), .Rest(rst), .Writ_Enable(we), .Del_Enable(de), .WR_Addr(wr_addr),
    .Data_IN(din), .Search_Start(start), .CMP_Din(key), .CMP_Mask(mask),
    .Busy(busy0), .Done(done0), .Match(match0), .Multi_Match(multi0),
    .Match_Addr(addr0), .Match_Count(cnt0)
  );

  param_cam #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .LANES(2)) u_dut2 (
    .Clk(clk), .Rest(rst), .Writ_Enable(we), .Del_Enable(de), .WR_Addr(wr_addr),
    .Data_IN(din), .Search_Start(start), .CMP_Din(key), .CMP_Mask(mask),
    .Busy(busy1), .Done(done1), .Match(match1), .Multi_Match(multi1),
    .Match_Addr(addr1), .Match_Count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic mem_op(input logic w, input logic d, input logic [1:0] a, input logic [3:0] v);
    @(negedge clk); we = w; de = d; wr_addr = a; din = v;
    @(negedge clk); we = 1'b0; de = 1'b0;
  endtask

  // mode 0: plain; 1: write wa/wd during the first Busy cycle; 2: write with the start
  task automatic search(input int sel, input logic [3:0] k, input logic [3:0] m,
                        input int mode, input logic [1:0] wa, input logic [3:0] wd,
                        input int exp_n, input string tag);
    int  busy_cnt;
    logic seen;
    busy_cnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    start = 1'b1; key = k; mask = m;
    if (mode == 2) begin we = 1'b1; wr_addr = wa; din = wd; end
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mode == 1 && i == 0) begin we = 1'b1; wr_addr = wa; din = wd; end
      if (mode == 1 && i == 1) we = 1'b0;
      if ((sel != 0) ? done1 : done0) begin seen = 1'b1; break; end
      if ((sel != 0) ? busy1 : busy0) busy_cnt++;
      @(negedge clk);
    end
    we = 1'b0;
    check({tag, ".busy_cycles"}, busy_cnt, exp_n);
    check({tag, ".done_seen"}, seen, 1'b1);
    check({tag, ".busy_at_done"}, (sel != 0) ? busy1 : busy0, 1'b0);
  endtask

  task automatic results(input int sel, input string tag, input logic m, input logic mm,
                         input logic [1:0] a, input logic [2:0] c);
    check({tag, ".match"}, (sel != 0) ? match1 : match0, m);
    check({tag, ".multi"}, (sel != 0) ? multi1 : multi0, mm);
    check({tag, ".addr"},  (sel != 0) ? addr1  : addr0,  a);
    check({tag, ".count"}, (sel != 0) ? cnt1   : cnt0,   c);
  endtask

  initial begin
    logic done_leak;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", busy0, 1'b0);
    check("rst.done", done0, 1'b0);
    results(0, "rst", 1'b0, 1'b0, 2'd0, 3'd0);

    // empty array finds nothing
    search(0, 4'h0, 4'hF, 0, 2'd0, 4'h0, 4, "empty");
    results(0, "empty", 1'b0, 1'b0, 2'd0, 3'd0);

    // two equal entries: lowest index reported, count 2
    mem_op(1'b1, 1'b0, 2'd1, 4'hA);
    mem_op(1'b1, 1'b0, 2'd3, 4'hA);
    search(0, 4'hA, 4'hF, 0, 2'd0, 4'h0, 4, "dual");
    results(0, "dual", 1'b1, 1'b1, 2'd1, 3'd2);
    @(negedge clk);
    check("hold.done_pulse", done0, 1'b0);
    check("hold.count", cnt0, 3'd2);
    check("hold.addr", addr0, 2'd1);

    // masked compare
    do_reset();
    mem_op(1'b1, 1'b0, 2'd0, 4'h5);
    search(0, 4'h7, 4'hD, 0, 2'd0, 4'h0, 4, "mask_d");
    results(0, "mask_d", 1'b1, 1'b0, 2'd0, 3'd1);
    search(0, 4'h7, 4'hA, 0, 2'd0, 4'h0, 4, "mask_a");
    results(0, "mask_a", 1'b0, 1'b0, 2'd0, 3'd0);
    mem_op(1'b1, 1'b0, 2'd3, 4'h0);
    search(0, 4'h7, 4'h0, 0, 2'd0, 4'h0, 4, "mask_0");
    results(0, "mask_0", 1'b1, 1'b1, 2'd0, 3'd2);

    // delete, write while busy, write-wins, overwrite
    do_reset();
    mem_op(1'b1, 1'b0, 2'd2, 4'h3);
    mem_op(1'b0, 1'b1, 2'd2, 4'h0);
    search(0, 4'h3, 4'hF, 0, 2'd0, 4'h0, 4, "deleted");
    results(0, "deleted", 1'b0, 1'b0, 2'd0, 3'd0);
    search(0, 4'h3, 4'hF, 1, 2'd2, 4'h3, 4, "busy_wr");
    results(0, "busy_wr", 1'b0, 1'b0, 2'd0, 3'd0);
    search(0, 4'h3, 4'hF, 0, 2'd0, 4'h0, 4, "after_busy_wr");
    results(0, "after_busy_wr", 1'b0, 1'b0, 2'd0, 3'd0);
    mem_op(1'b1, 1'b1, 2'd1, 4'h3);
    search(0, 4'h3, 4'hF, 0, 2'd0, 4'h0, 4, "wr_wins");
    results(0, "wr_wins", 1'b1, 1'b0, 2'd1, 3'd1);
    mem_op(1'b1, 1'b0, 2'd1, 4'h6);
    search(0, 4'h3, 4'hF, 0, 2'd0, 4'h0, 4, "overwrite_old");
    results(0, "overwrite_old", 1'b0, 1'b0, 2'd0, 3'd0);
    search(0, 4'h6, 4'hF, 0, 2'd0, 4'h0, 4, "overwrite_new");
    results(0, "overwrite_new", 1'b1, 1'b0, 2'd1, 3'd1);

    // write in the same cycle as the accepted start is seen by the search
    search(0, 4'hC, 4'hF, 2, 2'd0, 4'hC, 4, "same_cycle");
    results(0, "same_cycle", 1'b1, 1'b0, 2'd0, 3'd1);

    // reset two cycles into a search aborts it; write/start during reset ignored
    do_reset();
    mem_op(1'b1, 1'b0, 2'd1, 4'h5);
    @(negedge clk); start = 1'b1; key = 4'h5; mask = 4'hF;
    @(negedge clk); start = 1'b0;
    check("abort.busy_pre", busy0, 1'b1);
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wr_addr = 2'd2; din = 4'h5; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; we = 1'b0; start = 1'b0;
    check("abort.busy", busy0, 1'b0);
    check("abort.done", done0, 1'b0);
    results(0, "abort", 1'b0, 1'b0, 2'd0, 3'd0);
    done_leak = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done0) done_leak = 1'b1;
    end
    check("abort.no_done", done_leak, 1'b0);
    search(0, 4'h5, 4'hF, 0, 2'd0, 4'h0, 4, "post_abort");
    results(0, "post_abort", 1'b0, 1'b0, 2'd0, 3'd0);

    // two-lane instance
    do_reset();
    mem_op(1'b1, 1'b0, 2'd2, 4'h9);
    mem_op(1'b1, 1'b0, 2'd3, 4'h9);
    search(1, 4'h9, 4'hF, 0, 2'd0, 4'h0, 2, "lanes2");
    results(1, "lanes2", 1'b1, 1'b1, 2'd2, 3'd2);
    repeat (3) @(negedge clk);
    mem_op(1'b1, 1'b0, 2'd1, 4'h9);
    search(1, 4'h9, 4'hF, 0, 2'd0, 4'h0, 2, "lanes2_low");
    results(1, "lanes2_low", 1'b1, 1'b1, 2'd1, 3'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
